// File: rtl/demux_rr_sequencer.sv
// demux_rr_sequencer: steers a serial bit stream across up to four demux
// channels in round-robin order. BITS_PER_CH consecutive accepted bits go to
// one channel before it advances to the next enabled channel in the mask.
// A frame is one full pass over the enabled channels.
//
// Handshake: a bit is accepted on any rising edge where the FSM is not IDLE
// and din_valid=1. There is no backpressure. Each accepted bit appears one
// cycle later on d_out/sel, qualified by out_valid. In cycles that follow no
// accepted bit, d_out, out_valid and frame_done are 0 and sel holds its value.
module demux_rr_sequencer #(
  parameter int BITS_PER_CH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ch_mask,
  input  logic       din,
  input  logic       din_valid,
  output logic       d_out,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS_PER_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mask_q;
  logic [1:0]    ch_q;
  logic [1:0]    ch_next;
  logic [1:0]    ch_first;
  logic [CW-1:0] cnt_q;
  logic          start_ok;
  logic          acc;
  logic          adv;
  logic          wrap;
  logic          frame_end;
  logic          busy_d;

  assign state_dbg = state_q;

  // Next enabled channel above the current one, wrapping 3 -> 0; with a
  // single enabled channel the search lands back on the current index.
  always_comb begin
    ch_next = ch_q;
    for (int k = 4; k >= 1; k--) begin
      if (mask_q[ch_q + 2'(k)]) ch_next = ch_q + 2'(k);
    end
  end

  // Lowest enabled channel of the incoming mask, used at start.
  always_comb begin
    if (ch_mask[0])      ch_first = 2'd0;
    else if (ch_mask[1]) ch_first = 2'd1;
    else if (ch_mask[2]) ch_first = 2'd2;
    else                 ch_first = 2'd3;
  end

  assign start_ok  = (state_q == S_IDLE) && start && !stop && (ch_mask != 4'b0000);
  assign acc       = (state_q != S_IDLE) && din_valid;
  assign adv       = acc && (cnt_q == CNT_LAST);
  assign wrap      = (ch_next <= ch_q);
  assign frame_end = adv && wrap;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: stop is honoured only at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop && frame_end) state_d = S_IDLE;
        else if (stop)         state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: busy follows the state being entered so the registered
  // copy matches the current state.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  // Channel/mask/bit-counter bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= 4'b0000;
      ch_q   <= 2'd0;
      cnt_q  <= '0;
    end else if (start_ok) begin
      mask_q <= ch_mask;
      ch_q   <= ch_first;
      cnt_q  <= '0;
    end else if (acc) begin
      if (adv) begin
        cnt_q <= '0;
        ch_q  <= ch_next;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Registered demux outputs, one cycle behind the accepted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out      <= 1'b0;
      sel        <= 2'b00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      d_out      <= acc & din;
      out_valid  <= acc;
      frame_done <= frame_end;
      busy       <= busy_d;
      if (acc) sel <= ch_q;
    end
  end

endmodule

// File: doc/demux_rr_sequencer.md
DEMUX_RR_SEQUENCER -- requirements
Module: demux_rr_sequencer

Interface
REQ-001 The module SHALL have parameter BITS_PER_CH, default 1, meaning consecutive accepted bits steered to one channel before advancing; legal range 1..16.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin sequencing (sampled in IDLE only).
REQ-005 The module SHALL have port stop, input, 1 bit: request to end sequencing at the next frame boundary.
REQ-006 The module SHALL have port ch_mask, input, 4 bits: bit i=1 enables channel i; latched at start.
REQ-007 The module SHALL have port din, input, 1 bit: serial data bit.
REQ-008 The module SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-009 The module SHALL have port d_out, output, 1 bit: data to the 1:4 demux D input.
REQ-010 The module SHALL have port sel, output, 2 bits: channel select to the demux sel input.
REQ-011 The module SHALL have port out_valid, output, 1 bit: d_out/sel carry an accepted bit.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the last bit of a frame.
REQ-013 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, and STOPPING.
REQ-015 In IDLE, start=1 with stop=0 and ch_mask!=0 SHALL latch ch_mask to mask_q, set the current channel to the lowest enabled index, clear the bit counter, and move to RUN next cycle.
REQ-016 In IDLE, start with ch_mask==4'b0000, or start and stop both high, SHALL be ignored; the FSM SHALL stay in IDLE.
REQ-017 In RUN/STOPPING, a cycle with din_valid=1 SHALL be an accepted bit; din_valid is ignored in IDLE.
REQ-018 An accepted bit SHALL produce, on the next cycle (latency 1, registered), d_out=din, sel=current channel, and out_valid=1.
REQ-019 In any cycle following no accepted bit, out_valid, d_out, and frame_done SHALL all be 0; sel SHALL hold its last value.
REQ-020 The bit counter SHALL increment on each accepted bit; on the accepted bit where counter==BITS_PER_CH-1, it SHALL clear and the channel SHALL advance to the next enabled index in mask_q.
REQ-021 Channel advance SHALL search upward and wrap from 3 to 0, skipping disabled channels; a single enabled channel SHALL advance to itself.
REQ-022 A frame SHALL end when the advance wraps, i.e. the next channel index is less than or equal to the current one; frame_done SHALL be 1 in the same cycle as out_valid for that last bit.
REQ-023 stop=1 in RUN SHALL move the FSM to STOPPING; stop in STOPPING has no further effect.
REQ-024 In STOPPING, the frame-end accepted bit SHALL be output normally with frame_done, and the FSM SHALL then return to IDLE.
REQ-025 If stop arrives in RUN in the same cycle as a frame-end accepted bit, the FSM SHALL go directly to IDLE.
REQ-026 Changes on ch_mask while busy SHALL be ignored until the next start.
REQ-027 busy SHALL be registered and SHALL reflect the current state (0 in IDLE, 1 in RUN and STOPPING).

Reset
REQ-028 rst=1 SHALL force IDLE, mask_q=0, channel=0, counter=0, d_out=0, sel=2'b00, out_valid=0, frame_done=0, and busy=0 on the next edge, overriding all other inputs.
REQ-029 rst asserted mid-frame SHALL discard the partial frame; no frame_done SHALL be produced for it.

Verification
REQ-030 Bench: BITS_PER_CH=1, mask=1111, start, then din=1,0,1,1 valid on 4 consecutive cycles -> (sel,d_out)=(0,1),(1,0),(2,1),(3,1) one cycle later, frame_done only with sel=3.
REQ-031 Bench: mask=1010, 4 valid bits -> sel sequence 1,3,1,3, with frame_done on each sel=3 output.
REQ-032 Bench: BITS_PER_CH=2, mask=0011, 4 valid bits with a din_valid=0 gap after bit 2 -> sel 0,0,1,1, out_valid=0 and d_out=0 during the gap cycle, frame_done on the fourth bit.
REQ-033 Bench: start with mask=0000, and separately start with stop=1 -> busy stays 0 and out_valid stays 0.
REQ-034 Bench: mask=1111, stop after bit 1 -> bits 2-4 are still output, frame_done with sel=3, then busy=0; a fifth valid bit produces no output.
REQ-035 Bench: rst after bit 2 of a frame -> all outputs 0 next cycle and busy=0; a new start begins at the lowest enabled channel.
